uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- UART receive stage: the downstream partner of the transmitter, consuming its txd line on the far end of the link.
- Recovers 8N1 frames (start 0, 8 data bits LSB-first, stop 1) from asynchronous rxd.
- Samples rxd on an oversampled tick supplied by the baud-rate generator.
- Presents a byte with a ready flag (rda) until the host reads it.

Parameters:
- OVERSAMPLE, 16, baud_r_enable ticks per bit period; must be even and >= 4.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- baud_r_enable  input  1  oversample tick from the BRG, one clk wide, OVERSAMPLE per bit.
- rxd  input  1  serial line, asynchronous, idles high.
- data_read  input  1  host has consumed rx_data; clears rda, overrun and frame_err.
- rx_data  output  8  last good received byte.
- rda  output  1  receive data available.
- frame_err  output  1  sticky; stop bit sampled low.
- overrun  output  1  sticky; good frame completed while rda was already set.

Behaviour:
- Reset (async assert, sync-safe release):
  - rx_data = 8'h00; rda, frame_err and overrun = 0.
  - FSM in IDLE; counters 0; synchronizer flops = 1.
- rxd passes through a 2-flop synchronizer (rxd_s). All decisions use rxd_s, so there are 2 clk of latency.
- FSM state and counters advance only on cycles with baud_r_enable = 1. Flag clearing by data_read is evaluated every clk.
- IDLE: on a tick with rxd_s = 0, go to START with tick_cnt = 0.
- START: tick_cnt increments each tick. At tick_cnt = OVERSAMPLE/2-1 (mid start bit):
  - rxd_s = 0: go to DATA, tick_cnt = 0, bit_idx = 0.
  - rxd_s = 1: false start (glitch); return to IDLE with no flag change.
- DATA: at tick_cnt = OVERSAMPLE-1 (mid-bit), shift rxd_s into shift_reg[DATA_BITS-1], shifting right, so the first bit received ends up as bit 0.
  - Then reset tick_cnt and increment bit_idx.
  - After the bit with bit_idx = DATA_BITS-1, go to STOP.
- STOP: at tick_cnt = OVERSAMPLE-1, sample the stop bit.
  - rxd_s = 1 (good frame): load rx_data = shift_reg and set rda in the same clk. If rda was already 1 and data_read is not asserted that clk, set overrun. The new byte always overwrites. Return to IDLE.
  - rxd_s = 0 (framing error): set frame_err; rx_data and rda unchanged. Go to WAIT_HIGH.
- WAIT_HIGH: remain until a tick with rxd_s = 1, then go to IDLE. This prevents a break condition from being taken as repeated starts.
- data_read = 1 clears rda, overrun and frame_err on the next edge.
  - If good-frame completion coincides with data_read, rda remains 1 (new byte) and overrun is not set.
  - data_read with rda = 0 only clears the sticky flags.
- Latency: rda rises on the clk of the mid-stop-bit tick. That is about 9.5 bit periods plus 2 clk after the start-bit falling edge.
- Reset mid-frame aborts the frame, discards partial data, and returns to IDLE immediately.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit decision (start confirm, data, stop) is the majority of rxd_s at three consecutive ticks: tick_cnt = M-1, M, M+1, where M is the nominal sample point.
  - The decision is taken at M+1, and counters are aligned so bit periods stay OVERSAMPLE ticks.
  - A single-tick glitch on any bit is rejected.
- Undefined: single sample at the nominal point, as described above.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum: IDLE, START, DATA, STOP, WAIT_HIGH.
  - Constants: OVERSAMPLE default, DATA_BITS default, IDLE_LEVEL = 1'b1.
  - Shared with the transmitter.
- Sub-module uart_sync2: the 2-flop synchronizer, reset to 1, reusable for other async inputs.

Test Plan:
- Send byte 8'hA5 at OVERSAMPLE = 16 → rx_data = 8'hA5, rda = 1 at the mid-stop tick, frame_err = 0, overrun = 0.
- Pulse rxd low for 4 ticks, then high → return to IDLE at tick 7; no rda or flag change; a following frame 8'h3C is received correctly.
- Send 8'h55 with the stop bit forced 0, hold low 3 bit-times, then send 8'h0F:
  - frame_err = 1, rda = 0, rx_data unchanged.
  - Once the line idles high, 8'h0F is received and frame_err stays 1 until data_read.
- Send 8'h11, no data_read, then 8'h22 → rx_data = 8'h22, rda = 1, overrun = 1. A data_read pulse clears all three flags.
- Assert data_read on exactly the completion clk of frame 8'h77 while rda = 1 → rda = 1, overrun = 0, rx_data = 8'h77.
- Assert reset low mid DATA (bit 4) of 8'hFF, release, then send 8'h81 → outputs at reset values during reset; 8'h81 is received cleanly. With UART_RX_MAJORITY_EN, additionally inject a 1-tick glitch at the mid-point of bit 3 → byte still correct.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the receiver and the transmitter.
//   - rx_state_t : receiver frame-recovery states
//   - OVERSAMPLE_DEFAULT / DATA_BITS_DEFAULT : default link configuration
//   - IDLE_LEVEL : level of an idle serial line (mark)
//   - maj3()     : 2-of-3 vote used by the optional majority sampler
//                  (UART_RX_MAJORITY_EN)
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int   OVERSAMPLE_DEFAULT = 16;
   localparam int   DATA_BITS_DEFAULT  = 8;
   localparam logic IDLE_LEVEL         = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_t;

   // Two-out-of-three vote.
   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for a single asynchronous input. Both stages reset to
// RESET_VAL so a line that idles at that level produces no spurious edge when
// reset is released.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   d      in  asynchronous input
//   q      out synchronized copy of d (2 clk latency)
// -----------------------------------------------------------------------------
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic meta_d;
   logic sync_q;
   logic sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receive stage. rxd is synchronized, then a frame FSM clocked by the
// oversample tick confirms the start bit at its middle, samples each data bit
// (LSB first) and the stop bit at their middles, and hands good bytes to the
// host with a ready flag.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   When defined, every bit decision is a 2-of-3 vote over the synchronized
//   line at the nominal sample tick and its two neighbours. The decision is
//   taken one tick after the nominal point; only the start-bit confirmation is
//   delayed by a tick, so all later bit periods stay OVERSAMPLE ticks long.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-low reset
//   baud_r_enable  in   oversample tick, OVERSAMPLE ticks per bit
//   rxd            in   asynchronous serial line, idles high
//   data_read      in   host consumed rx_data; clears rda/overrun/frame_err
//   rx_data        out  last good received byte
//   rda            out  received data available
//   frame_err      out  sticky, stop bit sampled low
//   overrun        out  sticky, good frame completed while rda was still set
// -----------------------------------------------------------------------------
module uart_receiver
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
   parameter int DATA_BITS  = DATA_BITS_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 baud_r_enable,
   input  logic                 rxd,
   input  logic                 data_read,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rda,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   // Tick count at which a data/stop bit is decided.
   localparam logic [CNT_W-1:0] CNT_BIT_LAST = CNT_W'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
   // Start confirmation waits one extra tick so the vote window is centred on
   // the middle of the start bit; later bits inherit that one-tick offset.
   localparam logic [CNT_W-1:0] CNT_START_LAST = CNT_W'(OVERSAMPLE / 2);
`else
   localparam logic [CNT_W-1:0] CNT_START_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
`endif
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   // ---------------------------------------------------------------- sync
   logic rxd_s;

   uart_sync2 #(
      .RESET_VAL (IDLE_LEVEL)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rxd),
      .q     (rxd_s)
   );

   // ------------------------------------------------------ bit decision
   logic bit_val;

`ifdef UART_RX_MAJORITY_EN
   // Line level at the previous two ticks; the vote combines them with the
   // current tick's level.
   logic [1:0] hist_q;
   logic [1:0] hist_d;

   always_comb begin
      hist_d = hist_q;
      if (baud_r_enable) begin
         hist_d = {hist_q[0], rxd_s};
      end
   end

   assign bit_val = maj3({hist_q, rxd_s});
`else
   assign bit_val = rxd_s;
`endif

   // ------------------------------------------------------------ state
   rx_state_t            state_q;
   rx_state_t            state_d;
   logic [CNT_W-1:0]     tick_cnt_q;
   logic [CNT_W-1:0]     tick_cnt_d;
   logic [BIT_W-1:0]     bit_idx_q;
   logic [BIT_W-1:0]     bit_idx_d;
   logic [DATA_BITS-1:0] shift_reg_q;
   logic [DATA_BITS-1:0] shift_reg_d;
   logic [DATA_BITS-1:0] rx_data_q;
   logic [DATA_BITS-1:0] rx_data_d;
   logic                 rda_q;
   logic                 rda_d;
   logic                 frame_err_q;
   logic                 frame_err_d;
   logic                 overrun_q;
   logic                 overrun_d;

   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_reg_d = shift_reg_q;
      rx_data_d   = rx_data_q;
      rda_d       = rda_q;
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;

      // Host acknowledge is honoured every clk, independent of the tick.
      // A frame completing in the same clk overrides the clear below.
      if (data_read) begin
         rda_d       = 1'b0;
         frame_err_d = 1'b0;
         overrun_d   = 1'b0;
      end

      if (baud_r_enable) begin
         case (state_q)
            IDLE: begin
               if (rxd_s == 1'b0) begin
                  state_d    = START;
                  tick_cnt_d = '0;
               end
            end

            START: begin
               if (tick_cnt_q == CNT_START_LAST) begin
                  tick_cnt_d = '0;
                  if (bit_val == 1'b0) begin
                     state_d   = DATA;
                     bit_idx_d = '0;
                  end else begin
                     // Line went back high: a glitch, not a start bit.
                     state_d = IDLE;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + CNT_W'(1);
               end
            end

            DATA: begin
               if (tick_cnt_q == CNT_BIT_LAST) begin
                  tick_cnt_d = '0;
                  // Shift right, new bit at the MSB: the first (LSB) bit
                  // received lands in bit 0 after DATA_BITS shifts.
                  shift_reg_d                = shift_reg_q >> 1;
                  shift_reg_d[DATA_BITS-1]   = bit_val;
                  if (bit_idx_q == BIT_LAST) begin
                     state_d = STOP;
                  end else begin
                     bit_idx_d = bit_idx_q + BIT_W'(1);
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + CNT_W'(1);
               end
            end

            STOP: begin
               if (tick_cnt_q == CNT_BIT_LAST) begin
                  tick_cnt_d = '0;
                  if (bit_val == 1'b1) begin
                     rx_data_d = shift_reg_q;
                     rda_d     = 1'b1;
                     if (rda_q && !data_read) begin
                        overrun_d = 1'b1;
                     end
                     state_d = IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = WAIT_HIGH;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + CNT_W'(1);
               end
            end

            WAIT_HIGH: begin
               // Hold off until the line returns to mark so a break is not
               // re-read as a train of start bits.
               if (rxd_s == 1'b1) begin
                  state_d = IDLE;
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         tick_cnt_q  <= '0;
         bit_idx_q   <= '0;
         shift_reg_q <= '0;
         rx_data_q   <= '0;
         rda_q       <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
         hist_q      <= {2{IDLE_LEVEL}};
`endif
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_reg_q <= shift_reg_d;
         rx_data_q   <= rx_data_d;
         rda_q       <= rda_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef UART_RX_MAJORITY_EN
         hist_q      <= hist_d;
`endif
      end
   end

   assign rx_data   = rx_data_q;
   assign rda       = rda_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule
